clk_gate_cell: RTL and testbench
================================

Name: clk_gate_cell

Overview:
- Glitch-free clock-enable buffer: behavioural equivalent of a global clock buffer with clock enable.
- Drives a gated clock to downstream SRAM banks and compute tiles, so idle blocks stop toggling.
- Latch-based enable sampling during the clock low phase, optional hold-off hysteresis, test-mode override, optional activity counters.

Parameters:
- ENABLE_GATING, 1: 0 = pass-through (clk_o follows clk, clk_active = 1).
- HOLD_CYCLES, 0: extra gated-clock pulses kept after ce deasserts (0-255).
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  source clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; synchronous to clk.
- test_en  in  1  scan/test override; forces the clock on; quasi-static.
- clk_o  out  1  gated clock.
- clk_active  out  1  current latched enable; 1 = clk_o pulses on this high phase.
- stat_on_cycles  out  CNT_WIDTH  clk rising edges with gated clock running.
- stat_off_cycles  out  CNT_WIDTH  clk rising edges with gated clock suppressed.

Behaviour:
- One clock (clk); asynchronous active-low reset (rst_n). Both are fixed.
- Requested enable: en_req = ce | test_en | hold_active.
- Enable latch en_lat:
  - Transparent while clk = 0; holds while clk = 1.
  - Output logic: clk_o = clk & en_lat; clk_active = en_lat.
  - clk_o never shows a partial high pulse.
  - Changes on ce inside a high phase do not take effect until the next low phase.
- Timing:
  - ce stable-high during the low phase before rising edge N gives a full pulse at edge N.
  - ce low during that low phase suppresses the pulse (HOLD_CYCLES = 0).
  - Latency is zero cycles; the enable must be set up before the rising edge it qualifies.
- Hold counter, hold_cnt (8 bits), updated on posedge clk:
  - ce = 1 loads HOLD_CYCLES.
  - ce = 0 with hold_cnt != 0 decrements.
  - hold_active = (hold_cnt != 0).
  - After ce's last sampled-high edge, exactly HOLD_CYCLES more pulses appear, unless ce reasserts, which reloads the counter.
- Reset (rst_n = 0, asynchronous):
  - hold_cnt = 0.
  - Latch input forced to test_en only, so clk_o is low unless test_en = 1.
  - Counters cleared to 0.
  - clk_active reset value is 0 (with test_en = 0).
  - On deassertion, normal operation resumes at the next low phase.
- Reset asserted mid high phase:
  - With test_en = 0, en_lat clears immediately and clk_o drops.
  - This is the single permitted truncation.
- test_en = 1: clk_o = clk continuously, including during reset. ce and hold are ignored for output, but hold_cnt still updates.
- ENABLE_GATING = 0: no latch; clk_o = clk, clk_active = 1; the hold logic is optimised away.
- Simultaneous ce falling and hold reload on the same edge: the load wins (ce sampled as 1 at that edge).

Optional Feature:
- Macro CLKGATE_STATS_EN.
- Defined:
  - On each posedge clk (reset released), increment stat_on_cycles if en_lat = 1 at that edge, else stat_off_cycles.
  - Both counters saturate at all-ones.
- Undefined: both outputs are tied to 0 and no counter flops exist; the ports stay present for stable integration.

Decomposition:
- Package clk_gate_pkg holds:
  - HOLD_W = 8 and default CNT_WIDTH;
  - typedef clk_gate_stats_t (on/off counters struct).
- One sub-module, clk_gate_latch: latch plus AND, ports clk, en, rst_n, test_en, clk_o. It is isolated so synthesis can map it to an ICG cell.
- The hold counter and stats stay in the top module.

Test Plan:
- ce = 1 for 4 cycles then 0, HOLD_CYCLES = 0 -> exactly 4 clk_o pulses aligned to clk, no slivers; clk_active high only during those 4 cycles.
- ce toggled mid high phase (at 25% of period) -> clk_o unchanged until the next low phase; no glitch narrower than half a period.
- HOLD_CYCLES = 3, ce = 1 for 2 cycles -> 5 pulses total; ce re-pulsed during hold -> counter reloads to 3.
- rst_n asserted mid-burst with test_en = 0 -> clk_o low within the same phase, hold_cnt = 0. With test_en = 1 -> clk_o = clk throughout reset.
- ENABLE_GATING = 0 -> clk_o identical to clk for ce = 0 and ce = 1; clk_active = 1.
- CLKGATE_STATS_EN, 10 cycles with ce pattern 1100110000 -> stat_on_cycles = 4, stat_off_cycles = 6. Without the macro -> both read 0.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared constants and types for the clk_gate_cell clock-enable buffer.
package clk_gate_pkg;

    localparam int HOLD_W        = 8;
    localparam int CNT_WIDTH_DEF = 32;

    typedef struct packed {
        logic [CNT_WIDTH_DEF-1:0] on_cycles;
        logic [CNT_WIDTH_DEF-1:0] off_cycles;
    } clk_gate_stats_t;

endpackage

// File: rtl/clk_gate_latch.sv
// Low-phase transparent enable latch plus AND gate; kept separate so synthesis can map it onto an ICG cell.
module clk_gate_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic test_en,
    output logic clk_o,
    output logic en_lat
);

    logic r_en_lat;

    // Reset overrides the clock phase so a high pulse is cut short when test_en is low.
    always_latch begin
        if (!rst_n) begin
            r_en_lat = test_en;
        end else if (!clk) begin
            r_en_lat = en | test_en;
        end
    end

    assign en_lat = r_en_lat;
    assign clk_o  = clk & r_en_lat;

endmodule

// File: rtl/clk_gate_cell.sv
// Glitch-free clock-enable buffer with hold-off hysteresis and test override.
// Define CLKGATE_STATS_EN to build the on/off edge statistics counters.
module clk_gate_cell
    import clk_gate_pkg::*;
#(
    parameter int ENABLE_GATING = 1,
    parameter int HOLD_CYCLES   = 0,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 test_en,
    output logic                 clk_o,
    output logic                 clk_active,
    output logic [CNT_WIDTH-1:0] stat_on_cycles,
    output logic [CNT_WIDTH-1:0] stat_off_cycles
);

    logic w_en_lat;

    generate
        if (ENABLE_GATING != 0) begin : g_gate
            localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

            logic [HOLD_W-1:0] r_hold_cnt;
            logic              w_hold_active;
            logic              w_en_req;

            // A ce sample reloads the counter even while it is still draining.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold_cnt <= '0;
                end else if (ce) begin
                    r_hold_cnt <= HOLD_LOAD;
                end else if (w_hold_active) begin
                    r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                end
            end

            assign w_hold_active = (r_hold_cnt != '0);
            assign w_en_req      = ce | test_en | w_hold_active;

            clk_gate_latch u_latch (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (w_en_req),
                .test_en (test_en),
                .clk_o   (clk_o),
                .en_lat  (w_en_lat)
            );
        end else begin : g_pass
            assign clk_o    = clk;
            assign w_en_lat = 1'b1;
        end
    endgenerate

    assign clk_active = w_en_lat;

`ifdef CLKGATE_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] r_on_cnt;
    logic [CNT_WIDTH-1:0] r_off_cnt;

    // The latch is closed at the rising edge, so w_en_lat is the value that qualified this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on_cnt  <= '0;
            r_off_cnt <= '0;
        end else if (w_en_lat) begin
            if (r_on_cnt != CNT_MAX) begin
                r_on_cnt <= r_on_cnt + CNT_WIDTH'(1);
            end
        end else if (r_off_cnt != CNT_MAX) begin
            r_off_cnt <= r_off_cnt + CNT_WIDTH'(1);
        end
    end

    assign stat_on_cycles  = r_on_cnt;
    assign stat_off_cycles = r_off_cnt;
`else
    assign stat_on_cycles  = '0;
    assign stat_off_cycles = '0;
`endif

endmodule

// File: tb/tb_clk_gate_cell.sv
// Randomised bench for clk_gate_cell: hold-window reference model, per-phase compare and edge-alignment monitor.
`timescale 1ns/100ps
module tb_clk_gate_cell;

    localparam int H_HOLD = 3;
    localparam int CW0    = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic ce      = 1'b0;
    logic test_en = 1'b0;

    logic           clk_o_h, act_h, clk_o_0, act_0, clk_o_p, act_p;
    logic [31:0]    on_h, off_h, on_p, off_p;
    logic [CW0-1:0] on_0, off_0;

    int n_tests = 0;
    int n_fail  = 0;

    always #4 clk = ~clk;

    clk_gate_cell #(.ENABLE_GATING(1), .HOLD_CYCLES(H_HOLD), .CNT_WIDTH(32)) dut_h (
        .clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_h),
        .clk_active(act_h), .stat_on_cycles(on_h), .stat_off_cycles(off_h));

    clk_gate_cell #(.ENABLE_GATING(1), .HOLD_CYCLES(0), .CNT_WIDTH(CW0)) dut_0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_0),
        .clk_active(act_0), .stat_on_cycles(on_0), .stat_off_cycles(off_0));

    clk_gate_cell #(.ENABLE_GATING(0), .HOLD_CYCLES(0), .CNT_WIDTH(32)) dut_p (
        .clk(clk), .rst_n(rst_n), .ce(ce), .test_en(test_en), .clk_o(clk_o_p),
        .clk_active(act_p), .stat_on_cycles(on_p), .stat_off_cycles(off_p));

    // Index 0: hold=3, 1: hold=0 (4-bit counters), 2: pass-through.
    logic        o_clk [3];
    logic        o_act [3];
    logic [31:0] o_on  [3];
    logic [31:0] o_off [3];
    assign o_clk[0] = clk_o_h;  assign o_act[0] = act_h;
    assign o_clk[1] = clk_o_0;  assign o_act[1] = act_0;
    assign o_clk[2] = clk_o_p;  assign o_act[2] = act_p;
    assign o_on[0]  = on_h;     assign o_off[0] = off_h;
    assign o_on[1]  = 32'(on_0); assign o_off[1] = 32'(off_0);
    assign o_on[2]  = on_p;     assign o_off[2] = off_p;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge k pulses iff test_en, or ce was sampled high at any of the last hold+1 edges since reset.
    bit      hist[$];
    longint  m_on[3];
    longint  m_off[3];

    function automatic int hold_of(int k);
        return (k == 0) ? H_HOLD : 0;
    endfunction

    function automatic longint stat_max(int k);
        return (k == 1) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    function automatic bit any_last(int n);
        for (int i = 0; i < n; i++) begin
            if (i < hist.size() && hist[hist.size() - 1 - i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit pred_edge(int k);
        if (k == 2) return 1'b1;
        if (!rst_n) return test_en;
        return test_en | any_last(hold_of(k) + 1);
    endfunction

    function automatic bit pred_low(int k);
        if (k == 2) return 1'b1;
        if (!rst_n) return test_en;
        return test_en | ce | any_last(hold_of(k));
    endfunction

    function automatic longint exp_on(int k);
`ifdef CLKGATE_STATS_EN
        return m_on[k];
`else
        return (k < 0) ? 64'd1 : 64'd0;
`endif
    endfunction

    function automatic longint exp_off(int k);
`ifdef CLKGATE_STATS_EN
        return m_off[k];
`else
        return (k < 0) ? 64'd1 : 64'd0;
`endif
    endfunction

    task automatic clear_model();
        hist.delete();
        for (int k = 0; k < 3; k++) begin
            m_on[k]  = 0;
            m_off[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        bit ep[3];
        if (!rst_n) begin
            clear_model();
        end else begin
            hist.push_back(ce);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            ep[k] = pred_edge(k);
            if (rst_n) begin
                if (ep[k]) begin
                    if (m_on[k] < stat_max(k)) m_on[k]++;
                end else if (m_off[k] < stat_max(k)) begin
                    m_off[k]++;
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("clk_o_high[%0d]", k), 64'(o_clk[k]), 64'(ep[k]));
            chk($sformatf("active_high[%0d]", k), 64'(o_act[k]), 64'(ep[k]));
            chk($sformatf("stat_on[%0d]", k), 64'(o_on[k]), 64'(exp_on(k)));
            chk($sformatf("stat_off[%0d]", k), 64'(o_off[k]), 64'(exp_off(k)));
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n) clear_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("clk_o_low[%0d]", k), 64'(o_clk[k]), 64'd0);
            chk($sformatf("active_low[%0d]", k), 64'(o_act[k]), 64'(pred_low(k)));
            chk($sformatf("stat_on_low[%0d]", k), 64'(o_on[k]), 64'(exp_on(k)));
            chk($sformatf("stat_off_low[%0d]", k), 64'(o_off[k]), 64'(exp_off(k)));
        end
    end

    // Outside reset every gated-clock transition must coincide with a clk edge (multiples of 4 ns).
    always @(clk_o_h or clk_o_0 or clk_o_p) begin
        if (rst_n) chk("edge_align", 64'(longint'($realtime * 10.0) % 40), 64'd0);
    end

    int pc_h = 0;
    int pc_0 = 0;
    always @(posedge clk_o_h) pc_h++;
    always @(posedge clk_o_0) pc_0++;

    // Called at posedge+2; ce set here qualifies the next edge, then a stray mid-high toggle follows.
    task automatic step(input logic c);
        ce = c;
        @(posedge clk);
        #1 ce = 1'($urandom);
        #1;
    endtask

    task automatic do_reset(input logic te);
        #1;
        rst_n   = 1'b0;
        test_en = te;
        ce      = 1'b0;
        #0.5;
        chk("rst_cut_clk_o_h", 64'(clk_o_h), 64'(te));
        chk("rst_cut_clk_o_0", 64'(clk_o_0), 64'(te));
        chk("rst_cut_active_h", 64'(act_h), 64'(te));
        chk("rst_clk_o_pass", 64'(clk_o_p), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int s_h, s_0;
        logic [9:0] pat;

        #3;
        chk("reset_clk_o_h", 64'(clk_o_h), 64'd0);
        chk("reset_active_h", 64'(act_h), 64'd0);
        chk("reset_active_0", 64'(act_0), 64'd0);
        chk("reset_active_pass", 64'(act_p), 64'd1);
        chk("reset_stat_on_h", 64'(on_h), 64'd0);
        @(posedge clk);
        #2;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        s_h = pc_h; s_0 = pc_0;
        for (int i = 0; i < 10; i++) step(i < 4);
        chk("burst4_hold0_pulses", 64'(pc_0 - s_0), 64'd4);
        chk("burst4_hold3_pulses", 64'(pc_h - s_h), 64'd7);

        s_h = pc_h; s_0 = pc_0;
        for (int i = 0; i < 8; i++) step(i < 2);
        chk("ce2_hold3_pulses", 64'(pc_h - s_h), 64'd5);
        chk("ce2_hold0_pulses", 64'(pc_0 - s_0), 64'd2);

        s_h = pc_h;
        for (int i = 0; i < 10; i++) step(i == 0 || i == 3);
        chk("reload_hold3_pulses", 64'(pc_h - s_h), 64'd7);

        do_reset(1'b0);
        pat = 10'b1100110000;
        for (int i = 9; i >= 0; i--) step(pat[i]);
`ifdef CLKGATE_STATS_EN
        chk("pat_on_hold0", 64'(on_0), 64'd4);
        chk("pat_off_hold0", 64'(off_0), 64'd6);
        chk("pat_on_hold3", 64'(on_h), 64'd9);
        chk("pat_off_hold3", 64'(off_h), 64'd1);
        chk("pat_on_pass", 64'(on_p), 64'd10);
`else
        chk("pat_on_hold0", 64'(on_0), 64'd0);
        chk("pat_off_hold0", 64'(off_0), 64'd0);
        chk("pat_on_pass", 64'(on_p), 64'd0);
`endif
        for (int i = 0; i < 10; i++) step(1'b0);
`ifdef CLKGATE_STATS_EN
        chk("sat_off_hold0", 64'(off_0), 64'd15);
`else
        chk("sat_off_hold0", 64'(off_0), 64'd0);
`endif

        for (int i = 0; i < 3; i++) step(1'b1);
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) step(1'($urandom));
        for (int i = 0; i < 3; i++) step(1'b1);
        do_reset(1'b0);

        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) begin
                do_reset(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
            end else begin
                step(($urandom_range(0, 9) < ((i % 40 < 20) ? 7 : 2)) ? 1'b1 : 1'b0);
            end
        end
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
